mem_handshake: RTL and testbench

Parametrised, multicycle-friendly word memory with a request/ready handshake, byte-lane write enables, configurable wait states and out-of-range protection. It succeeds the fixed 32-bit × 50-word, single-cycle memory. It sits between the multicycle control FSM and the datapath: the controller issues one request and stalls until `ready` pulses.

---
 rtl/mem_handshake.sv | 107 ++++++++++
 tb/tb_mem_handshake.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_handshake.sv
// rtl/mem_handshake.sv - request/ready word memory with byte lanes and wait states
// Define MEM_RANGE_ERR_EN to report out-of-range accesses on err.
module mem_handshake #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 6,
  parameter int DEPTH       = 50,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [DATA_W-1:0]   wdata,
  output logic                busy,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                err
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
`ifdef MEM_RANGE_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                in_range;
  logic [DATA_W-1:0]   mem [DEPTH];

  // DEPTH may equal 2^ADDR_W, so compare with one extra bit.
  assign in_range = ({1'b0, addr_q} < DEPTH_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= address;
            be_q    <= byte_en;
            wdata_q <= wdata;
            busy    <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              cnt   <= 4'(WAIT_CYCLES - 1);
              state <= WAIT;
            end else begin
              state <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACCESS: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          err   <= ERR_EN & ~in_range;
          state <= IDLE;
          if (!we_q) begin
            rdata <= in_range ? mem[addr_q] : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is not reset; the async reset forces IDLE so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (state == ACCESS && we_q && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_q[b]) begin
          mem[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_handshake.sv
// tb/tb_mem_handshake.sv - scoreboard bench for mem_handshake, WAIT_CYCLES 0 and 3
module tb_mem_handshake;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          cyc;
  } exp_t;

`ifdef MEM_RANGE_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn  [2];
  logic        req   [2];
  logic        we    [2];
  logic [5:0]  addr  [2];
  logic [3:0]  be    [2];
  logic [31:0] wd    [2];
  logic        busy  [2];
  logic        ready [2];
  logic [31:0] rd    [2];
  logic        err   [2];

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] last_rd [2];
  logic [31:0] exp_mem [50];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_handshake #(.DATA_W(32), .ADDR_W(6), .DEPTH(50), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rstn[0]), .req(req[0]), .we(we[0]), .address(addr[0]),
    .byte_en(be[0]), .wdata(wd[0]), .busy(busy[0]), .ready(ready[0]),
    .rdata(rd[0]), .err(err[0]));

  mem_handshake #(.DATA_W(32), .ADDR_W(6), .DEPTH(50), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rstn[1]), .req(req[1]), .we(we[1]), .address(addr[1]),
    .byte_en(be[1]), .wdata(wd[1]), .busy(busy[1]), .ready(ready[1]),
    .rdata(rd[1]), .err(err[1]));

  function automatic int wc(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [31:0] pat(input int a);
    return 32'h5A000000 | (32'(a) << 8) | 32'(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int i, input logic [31:0] r, input logic e, input int c);
    exp_t x;
    x.rd = r; x.er = e; x.cyc = c;
    if (i == 0) q0.push_back(x); else q1.push_back(x);
  endtask

  // Monitor: every ready pulse must match the oldest scoreboard entry.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (ready[i] === 1'b1) begin
          if (qsize(i) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready dut%0d: ready high at cycle %0d, expected none", i, cyc);
          end else begin
            if (i == 0) x = q0.pop_front(); else x = q1.pop_front();
            chk($sformatf("rdata dut%0d", i), rd[i], x.rd);
            chk($sformatf("err dut%0d", i), {31'd0, err[i]}, {31'd0, x.er});
            chk($sformatf("ready_cycle dut%0d", i), 32'(cyc), 32'(x.cyc));
          end
        end
      end
    end
  end

  task automatic drain(input int i);
    for (int k = 0; k < 40 && qsize(i) != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (qsize(i) != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d: %0d responses outstanding, expected 0", i, qsize(i));
      if (i == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic access(input int i, input logic w, input int a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_er);
    @(negedge clk);
    req[i] = 1'b1; we[i] = w; addr[i] = 6'(a); be[i] = b; wd[i] = d;
    if (!w) last_rd[i] = exp_rd;
    push(i, last_rd[i], exp_er, cyc + 1 + wc(i) + 1);
    @(negedge clk);
    req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0;
    drain(i);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rstn[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0;
      be[i] = '0; wd[i] = '0; last_rd[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset busy", {31'd0, busy[i]}, 32'd0);
      chk("reset ready", {31'd0, ready[i]}, 32'd0);
      chk("reset rdata", rd[i], 32'd0);
      chk("reset err", {31'd0, err[i]}, 32'd0);
    end
    rstn[0] = 1'b1; rstn[1] = 1'b1;

    // WAIT_CYCLES=0: fill, full-word write/read, byte lanes
    for (int a = 0; a < 50; a++) begin
      access(0, 1'b1, a, 4'hF, pat(a), 32'h0, 1'b0);
      exp_mem[a] = pat(a);
    end
    access(0, 1'b1, 5, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
    access(0, 1'b0, 5, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
    access(0, 1'b1, 5, 4'b0101, 32'h11223344, 32'h0, 1'b0);
    access(0, 1'b0, 5, 4'hF, 32'h0, 32'hDE22BE44, 1'b0);
    exp_mem[5] = 32'hDE22BE44;

    // Out of range: writes dropped, reads zero, err only with the macro
    access(0, 1'b1, 55, 4'hF, 32'hFFFFFFFF, 32'h0, ERR_EN);
    access(0, 1'b0, 55, 4'hF, 32'h0, 32'h0, ERR_EN);
    access(0, 1'b0, 50, 4'h0, 32'h0, 32'h0, ERR_EN);
    access(0, 1'b0, 49, 4'h0, 32'h0, pat(49), 1'b0);
    for (int a = 0; a < 50; a++) access(0, 1'b0, a, 4'h0, 32'h0, exp_mem[a], 1'b0);

    // WAIT_CYCLES=3: baseline, then reset mid-WAIT aborting a write
    access(1, 1'b1, 7, 4'hF, 32'hA5A5A5A5, 32'h0, 1'b0);
    access(1, 1'b0, 7, 4'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 6'd7; be[1] = 4'hF; wd[1] = 32'h12345678;
    @(negedge clk);
    req[1] = 1'b0; we[1] = 1'b0;
    @(negedge clk);
    chk("busy before reset", {31'd0, busy[1]}, 32'd1);
    #2 rstn[1] = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy[1]}, 32'd0);
    chk("abort ready", {31'd0, ready[1]}, 32'd0);
    chk("abort rdata", rd[1], 32'd0);
    chk("abort err", {31'd0, err[1]}, 32'd0);
    last_rd[1] = 32'h0;
    @(negedge clk);
    rstn[1] = 1'b1;
    access(1, 1'b0, 7, 4'h0, 32'h0, 32'hA5A5A5A5, 1'b0);

    // req held through busy and into the ready cycle: exactly two accesses
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 6'd7; be[1] = 4'h0;
    push(1, 32'hA5A5A5A5, 1'b0, cyc + 1 + 4);
    push(1, 32'hA5A5A5A5, 1'b0, cyc + 1 + 9);
    last_rd[1] = 32'hA5A5A5A5;
    repeat (6) @(negedge clk);
    req[1] = 1'b0;
    drain(1);
    access(1, 1'b0, 60, 4'h0, 32'h0, 32'h0, ERR_EN);
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
